pipe_if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage pipelined CPU, directly upstream of the decode stage.
- Holds the PC and selects the next PC from decode-stage control (pcsource, wpcir) and branch/jump targets it computes itself.
- Drives the instruction-memory handshake and owns the IF/ID pipeline register.
- Presents pre-split instruction fields (op, func, rs, rt, rd, sa, imm, addr) and dpc4 to decode.
- Branches and jumps have one delay slot; nothing is flushed.

---
 rtl/pipe_if_stage.sv | 135 +++++++++++++
 tb/tb_pipe_if_stage.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage: PC register, next-PC select, imem handshake and IF/ID register.
// A redirect seen while imem is busy is parked in redir_pc until the delay slot arrives.
module pipe_if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [1:0]  pcsource,
    input  logic        wpcir,
    input  logic [31:0] rpc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic [31:0] dpc4,
    output logic [31:0] dinst,
    output logic        dvalid,
    output logic [5:0]  op,
    output logic [5:0]  func,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [31:0] sa,
    output logic [15:0] imm,
    output logic [25:0] addr,
    output logic [31:0] bpc,
    output logic [31:0] jpc
);

    typedef enum logic {
        FETCH      = 1'b0,
        REDIR_PEND = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] dpc4_reg, dpc4_next;
    logic [31:0] dinst_reg, dinst_next;
    logic        dvalid_reg, dvalid_next;
    logic [31:0] redir_pc_reg, redir_pc_next;
    logic [31:0] pc4;
    logic [31:0] npc;

    assign pc        = pc_reg;
    assign imem_addr = pc_reg;
    assign dpc4      = dpc4_reg;
    assign dinst     = dinst_reg;
    assign dvalid    = dvalid_reg;

    assign op   = dinst_reg[31:26];
    assign func = dinst_reg[5:0];
    assign rs   = dinst_reg[25:21];
    assign rt   = dinst_reg[20:16];
    assign rd   = dinst_reg[15:11];
    assign sa   = {27'b0, dinst_reg[10:6]};
    assign imm  = dinst_reg[15:0];
    assign addr = dinst_reg[25:0];

    // Branch and jump targets are relative to the instruction currently in decode.
    assign bpc = dpc4_reg + {{14{dinst_reg[15]}}, dinst_reg[15:0], 2'b00};
    assign jpc = {dpc4_reg[31:28], dinst_reg[25:0], 2'b00};
    assign pc4 = pc_reg + 32'd4;

    always_comb begin
        npc = pc4;
        case (pcsource)
            2'b00:   npc = pc4;
            2'b01:   npc = bpc;
            2'b10:   npc = rpc;
            default: npc = jpc;
        endcase
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        dpc4_next     = dpc4_reg;
        dinst_next    = dinst_reg;
        dvalid_next   = dvalid_reg;
        redir_pc_next = redir_pc_reg;
        if (wpcir) begin
            case (state_reg)
                FETCH: begin
                    if (imem_ready) begin
                        pc_next     = npc;
                        dpc4_next   = pc4;
                        dinst_next  = imem_rdata;
                        dvalid_next = 1'b1;
                    end else begin
                        dinst_next  = NOP_INST;
                        dvalid_next = 1'b0;
                        // The delay slot is still outstanding, so remember the target instead.
                        if (pcsource != 2'b00) begin
                            redir_pc_next = npc;
                            state_next    = REDIR_PEND;
                        end
                    end
                end
                REDIR_PEND: begin
                    if (imem_ready) begin
                        pc_next     = redir_pc_reg;
                        dpc4_next   = pc4;
                        dinst_next  = imem_rdata;
                        dvalid_next = 1'b1;
                        state_next  = FETCH;
                    end else begin
                        dinst_next  = NOP_INST;
                        dvalid_next = 1'b0;
                    end
                end
                default: state_next = FETCH;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_reg    <= FETCH;
            pc_reg       <= RESET_PC;
            dpc4_reg     <= 32'h0;
            dinst_reg    <= NOP_INST;
            dvalid_reg   <= 1'b0;
            redir_pc_reg <= 32'h0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            dpc4_reg     <= dpc4_next;
            dinst_reg    <= dinst_next;
            dvalid_reg   <= dvalid_next;
            redir_pc_reg <= redir_pc_next;
        end
    end

endmodule

// File: tb/tb_pipe_if_stage.sv
// Directed bench for pipe_if_stage: small instruction ROM, hand-computed expectations.
module tb_pipe_if_stage;

    logic        clock = 1'b0;
    logic        resetn;
    logic [1:0]  pcsource;
    logic        wpcir;
    logic [31:0] rpc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] pc, dpc4, dinst;
    logic        dvalid;
    logic [5:0]  op, func;
    logic [4:0]  rs, rt, rd;
    logic [31:0] sa;
    logic [15:0] imm;
    logic [25:0] addr;
    logic [31:0] bpc, jpc;

    int n_cmp = 0;
    int n_err = 0;

    pipe_if_stage dut (
        .clock(clock), .resetn(resetn), .pcsource(pcsource), .wpcir(wpcir), .rpc(rpc),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .pc(pc), .dpc4(dpc4), .dinst(dinst), .dvalid(dvalid),
        .op(op), .func(func), .rs(rs), .rt(rt), .rd(rd), .sa(sa), .imm(imm), .addr(addr),
        .bpc(bpc), .jpc(jpc)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h2001_0005;
            32'h0000_0004: mem_word = 32'h2002_0007;
            32'h0000_0008: mem_word = 32'h2003_0009;
            32'h0000_000C: mem_word = 32'h1000_FFFE; // beq $0,$0,-2
            32'h0000_0010: mem_word = 32'h2004_000B;
            32'h0000_001C: mem_word = 32'h0800_0020; // j 0x80
            32'h0000_0020: mem_word = 32'h2005_0001;
            32'h1000_0000: mem_word = 32'h0800_0010; // j addr=0x10
            default:       mem_word = {16'hACE0, a[15:0]};
        endcase
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] e_pc, input logic [31:0] e_inst,
                              input logic [31:0] e_dpc4, input logic e_valid);
        check({tag, ".pc"}, pc, e_pc);
        check({tag, ".dinst"}, dinst, e_inst);
        check({tag, ".dpc4"}, dpc4, e_dpc4);
        check({tag, ".dvalid"}, {31'b0, dvalid}, {31'b0, e_valid});
        $display("txn %-10s pc=%h dinst=%h dpc4=%h dvalid=%0b", tag, pc, dinst, dpc4, dvalid);
    endtask

    initial begin
        resetn = 1'b0; wpcir = 1'b1; pcsource = 2'b00; rpc = 32'h0; imem_ready = 1'b1;
        step();
        check_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        resetn = 1'b1;

        // straight-line fetch
        step(); check_ifid("seq0", 32'h4, 32'h2001_0005, 32'h4, 1'b1);
        check("op", {26'b0, op}, 32'd8);
        check("rt", {27'b0, rt}, 32'd1);
        check("imm", {16'b0, imm}, 32'd5);
        check("func", {26'b0, func}, 32'd5);
        check("imem_addr", imem_addr, 32'h4);
        step(); check_ifid("seq1", 32'h8, 32'h2002_0007, 32'h8, 1'b1);

        // decode stall for two cycles
        wpcir = 1'b0;
        step(); check_ifid("stall0", 32'h8, 32'h2002_0007, 32'h8, 1'b1);
        step(); check_ifid("stall1", 32'h8, 32'h2002_0007, 32'h8, 1'b1);
        wpcir = 1'b1;
        step(); check_ifid("resume", 32'hC, 32'h2003_0009, 32'hC, 1'b1);
        step(); check_ifid("beq_dec", 32'h10, 32'h1000_FFFE, 32'h10, 1'b1);
        check("bpc", bpc, 32'h8);

        // stall with a pending branch select holds; branch taken on release
        pcsource = 2'b01; wpcir = 1'b0;
        step(); check_ifid("br_stall", 32'h10, 32'h1000_FFFE, 32'h10, 1'b1);
        wpcir = 1'b1;
        step(); check_ifid("br_taken", 32'h8, 32'h2004_000B, 32'h14, 1'b1);

        // jr
        pcsource = 2'b10; rpc = 32'h40;
        step(); check_ifid("jr", 32'h40, 32'h2003_0009, 32'hC, 1'b1);
        rpc = 32'h1000_0000;
        step(); check_ifid("jr2", 32'h1000_0000, 32'hACE0_0040, 32'h44, 1'b1);
        pcsource = 2'b00;
        step(); check_ifid("j_dec", 32'h1000_0004, 32'h0800_0010, 32'h1000_0004, 1'b1);
        check("jpc", jpc, 32'h1000_0040);
        check("addr", {6'b0, addr}, 32'h10);
        pcsource = 2'b11;
        step(); check_ifid("j", 32'h1000_0040, 32'hACE0_0004, 32'h1000_0008, 1'b1);

        // memory wait with a jump in decode
        pcsource = 2'b10; rpc = 32'h1C;
        step(); check_ifid("to1c", 32'h1C, 32'hACE0_0040, 32'h1000_0044, 1'b1);
        pcsource = 2'b00;
        step(); check_ifid("j80_dec", 32'h20, 32'h0800_0020, 32'h20, 1'b1);
        check("jpc80", jpc, 32'h80);
        pcsource = 2'b11; imem_ready = 1'b0;
        step(); check_ifid("wait0", 32'h20, 32'h0, 32'h20, 1'b0);
        pcsource = 2'b00;
        step(); check_ifid("wait1", 32'h20, 32'h0, 32'h20, 1'b0);
        wpcir = 1'b0; imem_ready = 1'b1;
        step(); check_ifid("wait_stl", 32'h20, 32'h0, 32'h20, 1'b0);
        wpcir = 1'b1; imem_ready = 1'b0;
        step(); check_ifid("wait2", 32'h20, 32'h0, 32'h20, 1'b0);
        imem_ready = 1'b1;
        step(); check_ifid("dslot", 32'h80, 32'h2005_0001, 32'h24, 1'b1);
        step(); check_ifid("after", 32'h84, 32'hACE0_0080, 32'h84, 1'b1);

        // reset while a redirect is pending
        pcsource = 2'b10; rpc = 32'h200; imem_ready = 1'b0;
        step(); check_ifid("pend", 32'h84, 32'h0, 32'h84, 1'b0);
        pcsource = 2'b00; resetn = 1'b0;
        step(); check_ifid("rst_pend", 32'h0, 32'h0, 32'h0, 1'b0);
        resetn = 1'b1; imem_ready = 1'b1;
        step(); check_ifid("no_stale", 32'h4, 32'h2001_0005, 32'h4, 1'b1);

        // plain memory wait without redirect
        imem_ready = 1'b0;
        step(); check_ifid("bubble", 32'h4, 32'h0, 32'h4, 1'b0);
        imem_ready = 1'b1;
        step(); check_ifid("bub_res", 32'h8, 32'h2002_0007, 32'h8, 1'b1);

        // PC wrap-around
        pcsource = 2'b10; rpc = 32'hFFFF_FFFC;
        step(); check_ifid("to_top", 32'hFFFF_FFFC, 32'h2003_0009, 32'hC, 1'b1);
        pcsource = 2'b00;
        step(); check_ifid("wrap", 32'h0, 32'hACE0_FFFC, 32'h0, 1'b1);
        check("sa", sa, 32'd31);
        check("rd", {27'b0, rd}, 32'd31);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
